// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags with per-ROB-entry head checkpoints.
// Optional macro FL_BYPASS_EN forwards a retiring tag straight to T_idx when the list is empty.
module free_list #(
  parameter int NUM_PR   = 64,
  parameter int NUM_ARCH = 32,
  parameter int NUM_FL   = NUM_PR - NUM_ARCH,
  parameter int NUM_ROB  = 32,
  localparam int PRW     = $clog2(NUM_PR),
  localparam int ROBW    = $clog2(NUM_ROB),
  localparam int PTRW    = $clog2(NUM_FL) + 1,
  localparam int IDXW    = PTRW - 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic            dispatch_en,
  input  logic            dest_valid,
  input  logic [ROBW-1:0] ROB_tail_idx,
  input  logic            retire_en,
  input  logic [PRW-1:0]  Told_idx,
  input  logic            rollback_en,
  input  logic [ROBW-1:0] ROB_rollback_idx,
  output logic [PRW-1:0]  T_idx,
  output logic            FL_valid,
  output logic [PTRW-1:0] free_count
);

  logic [PRW-1:0]  entry_r [NUM_FL];
  logic [PTRW-1:0] ckpt_r [NUM_ROB];
  logic [PTRW-1:0] head_r;
  logic [PTRW-1:0] tail_r;

  logic [PTRW-1:0] count_s;
  logic [PTRW-1:0] head_next_s;
  logic            push_s;
  logic            pop_s;
  logic            bypass_s;
  logic            valid_s;
  logic            ckpt_we_s;

  // Derive push/pop qualifiers, occupancy and the head tag presented to dispatch.
  always_comb begin
    count_s = tail_r - head_r;
    push_s  = en & retire_en;
`ifdef FL_BYPASS_EN
    bypass_s = push_s & (count_s == {PTRW{1'b0}});
`else
    bypass_s = 1'b0;
`endif
    valid_s     = (count_s != {PTRW{1'b0}}) | bypass_s;
    pop_s       = en & dispatch_en & dest_valid & valid_s & ~rollback_en;
    ckpt_we_s   = en & dispatch_en & ~rollback_en;
    head_next_s = head_r + {{IDXW{1'b0}}, pop_s};
    if (bypass_s) begin
      T_idx = Told_idx;
    end else begin
      T_idx = entry_r[head_r[IDXW-1:0]];
    end
  end

  assign FL_valid   = valid_s;
  assign free_count = count_s;

  // Head and tail pointers; the MSB is the wrap bit so full and empty are distinguishable.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r <= {PTRW{1'b0}};
      tail_r <= PTRW'(NUM_FL);
    end else if (en) begin
      if (rollback_en) begin
        head_r <= ckpt_r[ROB_rollback_idx];
      end else begin
        head_r <= head_next_s;
      end
      if (push_s) begin
        tail_r <= tail_r + {{IDXW{1'b0}}, 1'b1};
      end
    end
  end

  // Tag storage: initially holds every non-architectural tag, then refilled by retirement.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FL; i++) begin
        entry_r[i] <= PRW'(NUM_ARCH + i);
      end
    end else if (push_s) begin
      entry_r[tail_r[IDXW-1:0]] <= Told_idx;
    end
  end

  // Per-ROB-slot checkpoint of the post-allocation head, restored on a mispredict.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROB; i++) begin
        ckpt_r[i] <= {PTRW{1'b0}};
      end
    end else if (ckpt_we_s) begin
      ckpt_r[ROB_tail_idx] <= head_next_s;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed and randomized checks of free_list against an absolute-counter reference model.
// The reference tracks pops/pushes as unbounded integers and an in-flight ROB queue for rollback targets.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       dispatch_en;
  logic       dest_valid;
  logic [4:0] ROB_tail_idx;
  logic       retire_en;
  logic [5:0] Told_idx;
  logic       rollback_en;
  logic [4:0] ROB_rollback_idx;
  logic [5:0] T_idx;
  logic       FL_valid;
  logic [5:0] free_count;

  free_list dut (
    .clock(clock), .reset(reset), .en(en), .dispatch_en(dispatch_en),
    .dest_valid(dest_valid), .ROB_tail_idx(ROB_tail_idx), .retire_en(retire_en),
    .Told_idx(Told_idx), .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx),
    .T_idx(T_idx), .FL_valid(FL_valid), .free_count(free_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: tags by absolute position, head/tail as plain counts, checkpoints as absolute heads.
  logic [5:0] mem [32];
  int         mh;
  int         mt;
  int         mck [32];
  int         rob_q [$];
  int         rob_tail;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = 6'(32 + i);
      mck[i] = 0;
    end
    mh = 0;
    mt = 32;
    rob_q.delete();
    rob_tail = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    en = 1'b1; dispatch_en = 1'b0; dest_valid = 1'b0; retire_en = 1'b0;
    rollback_en = 1'b0; Told_idx = 6'd0; ROB_tail_idx = 5'd0; ROB_rollback_idx = 5'd0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; dispatch_en = 1'b1; dest_valid = 1'b1; retire_en = 1'b1;
    Told_idx = 6'd3; rollback_en = 1'b0; ROB_tail_idx = 5'd1; ROB_rollback_idx = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: drive, compare outputs against the model mid-cycle, advance the model, clock.
  task automatic do_cycle(input bit e, input bit d, input bit dv, input int rt, input bit re,
                          input int told, input bit rb, input int rbi, input string tag);
    int cnt;
    int nh;
    bit byp;
    bit exp_v;
    bit pop;
    logic [5:0] exp_t;
    en = e; dispatch_en = d; dest_valid = dv; ROB_tail_idx = 5'(rt); retire_en = re;
    Told_idx = 6'(told); rollback_en = rb; ROB_rollback_idx = 5'(rbi);
    #1;
    cnt = mt - mh;
    byp = 1'b0;
`ifdef FL_BYPASS_EN
    byp = (cnt == 0) && e && re;
`endif
    exp_t = byp ? 6'(told) : mem[mh % 32];
    exp_v = (cnt != 0) || byp;
    chk({tag, ".T_idx"}, 32'(T_idx), 32'(exp_t));
    chk({tag, ".free_count"}, 32'(free_count), 32'(cnt));
    chk({tag, ".FL_valid"}, 32'(FL_valid), 32'(exp_v));
    pop = e && d && dv && exp_v && !rb;
    nh  = mh + (pop ? 1 : 0);
    if (e && d && !rb) mck[rt] = nh;
    if (e && rb) nh = mck[rbi];
    if (e && re) begin
      mem[mt % 32] = 6'(told);
      mt++;
    end
    mh = nh;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; dispatch_en = 1'b0; dest_valid = 1'b0; retire_en = 1'b0;
    Told_idx = 6'd0; rollback_en = 1'b0; ROB_tail_idx = 5'd0; ROB_rollback_idx = 5'd0;
    model_reset();

    // Reset state after two idle cycles.
    do_reset();
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, "idle0");
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, "idle1");
    quiet();
    chk("rst_T", 32'(T_idx), 32'd32);
    chk("rst_cnt", 32'(free_count), 32'd32);
    chk("rst_valid", 32'(FL_valid), 32'd1);

    for (int k = 0; k < 3; k++) begin
      do_cycle(1, 1, 1, k, 0, 0, 0, 0, "pop");
      quiet();
      chk("pop_T", 32'(T_idx), 32'(33 + k));
    end
    chk("pop3_cnt", 32'(free_count), 32'd29);

    // Drain to empty; further dispatch requests are refused.
    for (int k = 3; k < 32; k++) do_cycle(1, 1, 1, k, 0, 0, 0, 0, "drain");
    quiet();
    chk("empty_valid", 32'(FL_valid), 32'd0);
    chk("empty_cnt", 32'(free_count), 32'd0);
    do_cycle(1, 1, 1, 0, 0, 0, 0, 0, "pop_empty");
    do_cycle(0, 1, 1, 1, 1, 20, 0, 0, "en_off");
    quiet();
    chk("en_off_cnt", 32'(free_count), 32'd0);

    do_cycle(1, 0, 0, 0, 1, 7, 0, 0, "push7");
    quiet();
    chk("push7_valid", 32'(FL_valid), 32'd1);
    chk("push7_T", 32'(T_idx), 32'd7);
    do_cycle(1, 1, 1, 1, 0, 0, 0, 0, "pop7");
    quiet();
    chk("pop7_valid", 32'(FL_valid), 32'd0);

    // Branch checkpoint and rollback with head at entry 5.
    do_reset();
    for (int k = 0; k < 5; k++) do_cycle(1, 1, 1, 20 + k, 0, 0, 0, 0, "pre");
    do_cycle(1, 1, 0, 4, 0, 0, 0, 0, "branch");
    quiet();
    chk("branch_cnt", 32'(free_count), 32'd27);
    chk("branch_T", 32'(T_idx), 32'd37);
    do_cycle(1, 1, 0, 10, 0, 0, 0, 0, "pre10");
    for (int k = 5; k < 8; k++) do_cycle(1, 1, 1, k, 0, 0, 0, 0, "after_br");
    quiet();
    chk("after_br_cnt", 32'(free_count), 32'd24);
    do_cycle(1, 0, 0, 0, 0, 0, 1, 4, "rb4");
    quiet();
    chk("rb4_T", 32'(T_idx), 32'd37);
    chk("rb4_cnt", 32'(free_count), 32'd27);

    // Rollback, retire and dispatch in one cycle.
    do_cycle(1, 1, 1, 8, 0, 0, 0, 0, "pop8");
    do_cycle(1, 1, 1, 9, 0, 0, 0, 0, "pop9");
    do_cycle(1, 1, 1, 10, 1, 9, 1, 8, "combo");
    quiet();
    chk("combo_T", 32'(T_idx), 32'd38);
    chk("combo_cnt", 32'(free_count), 32'd27);
    do_cycle(1, 0, 0, 0, 0, 0, 1, 10, "rb10");
    quiet();
    chk("rb10_T", 32'(T_idx), 32'd37);
    chk("rb10_cnt", 32'(free_count), 32'd28);
    for (int k = 0; k < 27; k++) do_cycle(1, 1, 1, 12 + (k % 16), 0, 0, 0, 0, "walk");
    quiet();
    chk("old_tail_T", 32'(T_idx), 32'd9);
    chk("old_tail_cnt", 32'(free_count), 32'd1);

    // Empty list with a retire and a dispatch in the same cycle.
    do_cycle(1, 1, 1, 0, 0, 0, 0, 0, "to_empty");
    en = 1'b1; dispatch_en = 1'b1; dest_valid = 1'b1; retire_en = 1'b1; Told_idx = 6'd12;
    rollback_en = 1'b0;
    #1;
`ifdef FL_BYPASS_EN
    chk("byp_T", 32'(T_idx), 32'd12);
    chk("byp_valid", 32'(FL_valid), 32'd1);
`else
    chk("nobyp_valid", 32'(FL_valid), 32'd0);
`endif
    do_cycle(1, 1, 1, 1, 1, 12, 0, 0, "byp");
    quiet();
`ifdef FL_BYPASS_EN
    chk("byp_next_cnt", 32'(free_count), 32'd0);
`else
    chk("nobyp_next_cnt", 32'(free_count), 32'd1);
    chk("nobyp_next_T", 32'(T_idx), 32'd12);
`endif

    // Randomized traffic with an in-flight ROB queue supplying legal rollback targets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bit e, d, dv, re, rb;
      int rbi, pos, told, rt;
      e   = $urandom_range(0, 9) != 0;
      d   = ($urandom_range(0, 1) == 1) && (rob_q.size() < 32);
      dv  = $urandom_range(0, 3) != 0;
      re  = ((mt - mh) < 32) && ($urandom_range(0, 2) == 0);
      told = $urandom_range(0, 63);
      rt  = rob_tail;
      rb  = (rob_q.size() > 0) && ($urandom_range(0, 11) == 0);
      pos = 0;
      rbi = 0;
      if (rb) begin
        pos = $urandom_range(0, rob_q.size() - 1);
        rbi = rob_q[pos];
        if (mt + (re ? 1 : 0) - mck[rbi] > 32) rb = 1'b0;
      end
      do_cycle(e, d, dv, rt, re, told, rb, rbi, "rand");
      if (e) begin
        if (rb) begin
          while (rob_q.size() > pos + 1) void'(rob_q.pop_back());
          rob_tail = (rbi + 1) % 32;
        end else if (d) begin
          rob_q.push_back(rt);
          rob_tail = (rt + 1) % 32;
        end
        if (re && rob_q.size() > 0) void'(rob_q.pop_front());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
